// File: rtl/rf_alu_pkg.sv
// Shared definitions for the RF/ALU command sequencer and its opcode decoder.
//   - Supported LEGv8 R-format opcodes
//   - ALUOp class encodings
//   - Sequencer FSM state enum
//   - R-format field layout and slice helper
package rf_alu_pkg;

  localparam logic [10:0] OP_AND   = 11'b10001010000;
  localparam logic [10:0] OP_ORR   = 11'b10101010000;
  localparam logic [10:0] OP_ADD   = 11'b10001011000;
  localparam logic [10:0] OP_SUB   = 11'b11001011000;
  localparam logic [10:0] OP_PASSB = 11'b11111000010;
  localparam logic [10:0] OP_NOR   = 11'b11101010000;

  localparam logic [1:0] ALUOP_ADD   = 2'd0;  // add / idle
  localparam logic [1:0] ALUOP_RTYPE = 2'd2;  // R-type, ALU control looks at Opcode

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_WB,
    ST_RESP
  } state_t;

  typedef struct packed {
    logic [10:0] opcode;
    logic [4:0]  rm;
    logic [5:0]  shamt;
    logic [4:0]  rn;
    logic [4:0]  rd;
  } rfmt_t;

  function automatic rfmt_t split_rfmt(input logic [31:0] instr);
    return rfmt_t'(instr);
  endfunction

endpackage

// File: rtl/rf_alu_opdecode.sv
// Combinational R-format opcode decoder.
//   opcode     in  11  raw opcode field
//   supported  out 1   opcode is one of the six supported operations
//   alu_op     out 2   RTYPE when supported, ADD otherwise
//   opcode_out out 11  opcode when supported, zero otherwise
module rf_alu_opdecode
  import rf_alu_pkg::*;
(
  input  logic [10:0] opcode,
  output logic        supported,
  output logic [1:0]  alu_op,
  output logic [10:0] opcode_out
);

  always_comb begin
    supported = 1'b0;
    case (opcode)
      OP_AND, OP_ORR, OP_ADD, OP_SUB, OP_PASSB, OP_NOR: supported = 1'b1;
      default:                                          supported = 1'b0;
    endcase
    alu_op     = supported ? ALUOP_RTYPE : ALUOP_ADD;
    opcode_out = supported ? opcode : 11'd0;
  end

endmodule

// File: rtl/rf_alu_sequencer.sv
// Command-side sequencer for the register-file/ALU datapath.
// Accepts one R-format execute or one register-load command per handshake,
// drives RF read addresses and ALU control, captures the result, writes it
// back to Rd and returns it on a valid/ready response channel.
//   clock, reset                      clock, synchronous active-high reset
//   cmd_valid/cmd_ready               command handshake
//   cmd_load, cmd_instr, cmd_data     command payload
//   Read1, Read2                      RF read addresses (Rn, Rm)
//   WriteReg, WriteData, RegWrite     RF write port
//   ALUOp, Opcode                     ALU control
//   ALU_Result, Zero                  ALU outputs
//   resp_valid/resp_ready             response handshake
//   resp_result, resp_zero, resp_err  response payload
module rf_alu_sequencer
  import rf_alu_pkg::*;
#(
  parameter int XZR_IDX = 31,
  parameter int DATA_W  = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_load,
  input  logic [31:0]       cmd_instr,
  input  logic [DATA_W-1:0] cmd_data,
  output logic [4:0]        Read1,
  output logic [4:0]        Read2,
  output logic [4:0]        WriteReg,
  output logic [DATA_W-1:0] WriteData,
  output logic              RegWrite,
  output logic [1:0]        ALUOp,
  output logic [10:0]       Opcode,
  input  logic [DATA_W-1:0] ALU_Result,
  input  logic              Zero,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_result,
  output logic              resp_zero,
  output logic              resp_err
);

  localparam logic [4:0] XZR = 5'(XZR_IDX);

  state_t state, next_state;
  rfmt_t  cmd_f;

  logic [10:0]       op_p1;
  logic [4:0]        rn_p1, rm_p1, rd_p1;
  logic [DATA_W-1:0] result_p2;
  logic              zero_p2, err_p2;

  logic              dec_supported;
  logic [1:0]        dec_alu_op;
  logic [10:0]       dec_opcode;

  // shamt has no meaning for any supported operation
  logic unused_shamt;

  assign cmd_f        = split_rfmt(cmd_instr);
  assign unused_shamt = ^cmd_f.shamt;

  rf_alu_opdecode u_opdecode (
    .opcode     (op_p1),
    .supported  (dec_supported),
    .alu_op     (dec_alu_op),
    .opcode_out (dec_opcode)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      op_p1     <= '0;
      rn_p1     <= '0;
      rm_p1     <= '0;
      rd_p1     <= '0;
      result_p2 <= '0;
      zero_p2   <= 1'b0;
      err_p2    <= 1'b0;
    end else begin
      state <= next_state;
      case (state)
        // command latch
        ST_IDLE: begin
          if (cmd_valid) begin
            op_p1 <= cmd_f.opcode;
            rd_p1 <= cmd_f.rd;
            if (cmd_load) begin
              result_p2 <= cmd_data;
              zero_p2   <= (cmd_data == '0);
              err_p2    <= 1'b0;
            end else begin
              // read addresses only move for executes; loads leave them held
              rn_p1 <= cmd_f.rn;
              rm_p1 <= cmd_f.rm;
            end
          end
        end
        // ALU result capture
        ST_EXEC: begin
          result_p2 <= ALU_Result;
          zero_p2   <= Zero;
          err_p2    <= ~dec_supported;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    next_state = state;
    cmd_ready  = 1'b0;
    RegWrite   = 1'b0;
    resp_valid = 1'b0;
    ALUOp      = ALUOP_ADD;
    Opcode     = 11'd0;
    case (state)
      ST_IDLE: begin
        cmd_ready = ~reset;
        if (cmd_valid && !reset) next_state = cmd_load ? ST_WB : ST_EXEC;
      end
      ST_EXEC: begin
        ALUOp      = dec_alu_op;
        Opcode     = dec_opcode;
        next_state = ST_WB;
      end
      ST_WB: begin
        // unaffected by reset in this cycle: the write lands on the reset edge
        RegWrite   = ~err_p2 && (rd_p1 != XZR);
        next_state = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  assign Read1       = rn_p1;
  assign Read2       = rm_p1;
  assign WriteReg    = rd_p1;
  assign WriteData   = result_p2;
  assign resp_result = result_p2;
  assign resp_zero   = zero_p2;
  assign resp_err    = err_p2;

endmodule

// File: tb/tb_rf_alu_sequencer.sv
// Scoreboard bench for rf_alu_sequencer with an attached RF and ALU model.
module tb_rf_alu_sequencer;
  import rf_alu_pkg::*;

  typedef struct packed {
    logic [63:0] res;
    logic        zero;
    logic        err;
  } resp_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [63:0] data;
  } wr_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_load;
  logic [31:0] cmd_instr;
  logic [63:0] cmd_data;
  logic [4:0]  Read1, Read2, WriteReg;
  logic [63:0] WriteData;
  logic        RegWrite;
  logic [1:0]  ALUOp;
  logic [10:0] Opcode;
  logic [63:0] ALU_Result;
  logic        Zero;
  logic        resp_valid, resp_ready;
  logic [63:0] resp_result;
  logic        resp_zero, resp_err;

  logic [63:0] rf [32];
  logic [63:0] alu_a, alu_b;

  resp_t resp_q[$];
  wr_t   wr_q[$];
  int    checks = 0;
  int    fails = 0;
  int    resp_cnt = 0;

  always #5 clock = ~clock;

  rf_alu_sequencer #(.XZR_IDX(31), .DATA_W(64)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_load(cmd_load),
    .cmd_instr(cmd_instr), .cmd_data(cmd_data),
    .Read1(Read1), .Read2(Read2), .WriteReg(WriteReg), .WriteData(WriteData),
    .RegWrite(RegWrite), .ALUOp(ALUOp), .Opcode(Opcode),
    .ALU_Result(ALU_Result), .Zero(Zero),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .resp_zero(resp_zero), .resp_err(resp_err)
  );

  // register file model
  always @(posedge clock) begin
    if (RegWrite) rf[WriteReg] <= WriteData;
  end

  // ALU model
  always_comb begin
    alu_a      = rf[Read1];
    alu_b      = rf[Read2];
    ALU_Result = alu_a + alu_b;
    if (ALUOp == 2'd2) begin
      case (Opcode)
        OP_AND:   ALU_Result = alu_a & alu_b;
        OP_ORR:   ALU_Result = alu_a | alu_b;
        OP_ADD:   ALU_Result = alu_a + alu_b;
        OP_SUB:   ALU_Result = alu_a - alu_b;
        OP_PASSB: ALU_Result = alu_b;
        OP_NOR:   ALU_Result = ~(alu_a | alu_b);
        default:  ALU_Result = alu_a + alu_b;
      endcase
    end
    Zero = (ALU_Result == 64'd0);
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // response and write-back monitor
  always @(negedge clock) begin
    resp_t e;
    wr_t   w;
    if (resp_valid && resp_ready) begin
      if (resp_q.size() == 0) begin
        checks++; fails++;
        $display("FAIL unexpected_resp: got result %h with no response expected", resp_result);
      end else begin
        e = resp_q.pop_front();
        check("resp_result", resp_result, e.res);
        check("resp_zero", {63'd0, resp_zero}, {63'd0, e.zero});
        check("resp_err", {63'd0, resp_err}, {63'd0, e.err});
      end
      resp_cnt++;
    end
    if (RegWrite) begin
      if (wr_q.size() == 0) begin
        checks++; fails++;
        $display("FAIL unexpected_write: got RegWrite to R%0d data %h, none expected", WriteReg, WriteData);
      end else begin
        w = wr_q.pop_front();
        check("write_reg", {59'd0, WriteReg}, {59'd0, w.rd});
        check("write_data", WriteData, w.data);
      end
    end
  end

  function automatic logic [31:0] rins(input logic [10:0] op, input logic [4:0] rm,
                                       input logic [4:0] rn, input logic [4:0] rd);
    return {op, rm, 6'd0, rn, rd};
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!cmd_ready && n < 20) begin
      @(posedge clock); #1;
      n++;
    end
  endtask

  task automatic wait_resp(input int target);
    int n = 0;
    while (resp_cnt < target && n < 30) begin
      @(posedge clock);
      n++;
    end
    check("resp_timeout", {63'd0, resp_cnt >= target}, 64'd1);
  endtask

  // Issue one command with resp_ready held 1, checking EXEC drive and latencies.
  task automatic do_cmd(input string nm, input logic ld, input logic [31:0] ins,
                        input logic [63:0] dat, input logic [63:0] er,
                        input logic ez, input logic ee, input logic ew);
    int wr_cyc = 0;
    int rv_cyc = 0;
    resp_q.push_back(resp_t'({er, ez, ee}));
    if (ew) wr_q.push_back(wr_t'({ins[4:0], er}));
    @(posedge clock); #1;
    cmd_valid = 1'b1; cmd_load = ld; cmd_instr = ins; cmd_data = dat;
    wait_ready();
    @(posedge clock); #1;
    cmd_valid = 1'b0;
    for (int c = 1; c <= 20 && rv_cyc == 0; c++) begin
      @(negedge clock);
      if (c == 1 && !ld) begin
        check({nm, "_aluop"}, {62'd0, ALUOp}, ee ? 64'd0 : 64'd2);
        check({nm, "_opcode"}, {53'd0, Opcode}, ee ? 64'd0 : {53'd0, ins[31:21]});
        check({nm, "_read1"}, {59'd0, Read1}, {59'd0, ins[9:5]});
        check({nm, "_read2"}, {59'd0, Read2}, {59'd0, ins[20:16]});
      end
      if (RegWrite && wr_cyc == 0) wr_cyc = c;
      if (resp_valid) rv_cyc = c;
    end
    check({nm, "_resp_latency"}, 64'(rv_cyc), ld ? 64'd2 : 64'd3);
    check({nm, "_wr_cycle"}, 64'(wr_cyc), ew ? (ld ? 64'd1 : 64'd2) : 64'd0);
    @(posedge clock); #1;
  endtask

  task automatic check_reset_values(input string nm);
    check({nm, "_cmd_ready"}, {63'd0, cmd_ready}, 64'd1);
    check({nm, "_regwrite"}, {63'd0, RegWrite}, 64'd0);
    check({nm, "_resp_valid"}, {63'd0, resp_valid}, 64'd0);
    check({nm, "_resp_err"}, {63'd0, resp_err}, 64'd0);
    check({nm, "_resp_zero"}, {63'd0, resp_zero}, 64'd0);
    check({nm, "_read1"}, {59'd0, Read1}, 64'd0);
    check({nm, "_read2"}, {59'd0, Read2}, 64'd0);
    check({nm, "_writereg"}, {59'd0, WriteReg}, 64'd0);
    check({nm, "_writedata"}, WriteData, 64'd0);
    check({nm, "_resp_result"}, resp_result, 64'd0);
    check({nm, "_aluop"}, {62'd0, ALUOp}, 64'd0);
    check({nm, "_opcode"}, {53'd0, Opcode}, 64'd0);
  endtask

  localparam logic [63:0] V5  = 64'h5555555555555555;
  localparam logic [63:0] V10 = 64'hAAAAAAAAAAAAAAAA;
  localparam logic [63:0] ONES = 64'hFFFFFFFFFFFFFFFF;

  initial begin
    int target;
    for (int i = 0; i < 32; i++) rf[i] = 64'd0;
    reset = 1'b1; resp_ready = 1'b1;
    // a command offered during reset must be dropped
    cmd_valid = 1'b1; cmd_load = 1'b1; cmd_instr = 32'd7; cmd_data = 64'h1234;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("cmd_ready_in_reset", {63'd0, cmd_ready}, 64'd0);
    @(posedge clock); #1;
    reset = 1'b0; cmd_valid = 1'b0;
    @(negedge clock);
    check_reset_values("post_reset");

    // loads
    do_cmd("load_r5", 1'b1, 32'd5, V5, V5, 1'b0, 1'b0, 1'b1);
    do_cmd("load_r10", 1'b1, 32'd10, V10, V10, 1'b0, 1'b0, 1'b1);

    // executes, Rn=5 Rm=10 Rd=1
    do_cmd("and",   1'b0, rins(OP_AND,   5'd10, 5'd5, 5'd1), 64'd0, 64'd0, 1'b1, 1'b0, 1'b1);
    do_cmd("orr",   1'b0, rins(OP_ORR,   5'd10, 5'd5, 5'd1), 64'd0, ONES, 1'b0, 1'b0, 1'b1);
    do_cmd("add",   1'b0, rins(OP_ADD,   5'd10, 5'd5, 5'd1), 64'd0, ONES, 1'b0, 1'b0, 1'b1);
    do_cmd("sub",   1'b0, rins(OP_SUB,   5'd10, 5'd5, 5'd1), 64'd0, 64'hAAAAAAAAAAAAAAAB, 1'b0, 1'b0, 1'b1);
    do_cmd("passb", 1'b0, rins(OP_PASSB, 5'd10, 5'd5, 5'd1), 64'd0, V10, 1'b0, 1'b0, 1'b1);
    do_cmd("nor",   1'b0, rins(OP_NOR,   5'd10, 5'd5, 5'd1), 64'd0, 64'd0, 1'b1, 1'b0, 1'b1);
    check("r1_after_nor", rf[1], 64'd0);

    // unsupported opcode: ALU falls back to add, flagged as error, no write
    do_cmd("badop", 1'b0, rins(11'd0, 5'd10, 5'd5, 5'd1), 64'd0, ONES, 1'b0, 1'b1, 1'b0);
    // write to the zero register is suppressed but the result is returned
    do_cmd("add_xzr", 1'b0, rins(OP_ADD, 5'd10, 5'd5, 5'd31), 64'd0, ONES, 1'b0, 1'b0, 1'b0);

    // backpressure: ADD into R2, stall 5 cycles, a load of 0 into R3 waits
    target = resp_cnt + 2;
    resp_ready = 1'b0;
    resp_q.push_back(resp_t'({ONES, 1'b0, 1'b0}));
    resp_q.push_back(resp_t'({64'd0, 1'b1, 1'b0}));
    wr_q.push_back(wr_t'({5'd2, ONES}));
    wr_q.push_back(wr_t'({5'd3, 64'd0}));
    @(posedge clock); #1;
    cmd_valid = 1'b1; cmd_load = 1'b0; cmd_instr = rins(OP_ADD, 5'd10, 5'd5, 5'd2);
    wait_ready();
    @(posedge clock); #1;
    cmd_load = 1'b1; cmd_instr = 32'd3; cmd_data = 64'd0;
    for (int n = 0; n < 10 && !resp_valid; n++) @(negedge clock);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clock);
      check("stall_resp_valid", {63'd0, resp_valid}, 64'd1);
      check("stall_resp_result", resp_result, ONES);
      check("stall_cmd_ready", {63'd0, cmd_ready}, 64'd0);
    end
    @(posedge clock); #1;
    resp_ready = 1'b1;
    @(posedge clock);        // handshake edge
    @(negedge clock);
    check("after_handshake_idle", {63'd0, cmd_ready}, 64'd1);
    @(posedge clock); #1;    // load accepted here
    cmd_valid = 1'b0;
    wait_resp(target);
    check("r3_loaded_zero", rf[3], 64'd0);

    // reset during EXEC abandons the command
    @(posedge clock); #1;
    cmd_valid = 1'b1; cmd_load = 1'b0; cmd_instr = rins(OP_ADD, 5'd10, 5'd5, 5'd3);
    wait_ready();
    @(posedge clock); #1;
    cmd_valid = 1'b0; reset = 1'b1;
    @(negedge clock);
    check("rst_exec_aluop", {62'd0, ALUOp}, 64'd2);
    check("rst_exec_cmd_ready", {63'd0, cmd_ready}, 64'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check_reset_values("rst_exec");
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("rst_exec_no_write", {63'd0, RegWrite}, 64'd0);
      check("rst_exec_no_resp", {63'd0, resp_valid}, 64'd0);
    end
    check("r3_untouched", rf[3], 64'd0);

    // next command completes normally
    do_cmd("after_reset_sub", 1'b0, rins(OP_SUB, 5'd10, 5'd5, 5'd4), 64'd0,
           64'hAAAAAAAAAAAAAAAB, 1'b0, 1'b0, 1'b1);
    check("r4_written", rf[4], 64'hAAAAAAAAAAAAAAAB);

    repeat (3) @(posedge clock);
    check("resp_q_drained", 64'(resp_q.size()), 64'd0);
    check("wr_q_drained", 64'(wr_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/rf_alu_sequencer.md
# rf_alu_sequencer

Command-side initiator for the register-file/ALU datapath. It accepts one LEGv8 R-format instruction, or one register-load command, per valid/ready handshake. It drives the RF read ports and ALU control, captures the ALU result, and writes the result back to Rd. It then returns the result on a valid/ready response channel. It sits between instruction issue and the RFandALU datapath and replaces hand-driven register/ALU stimulus with a cycle-exact hardware sequencer.

## Interface
- `XZR_IDX`, default 31: register index treated as the zero register; writes to it are suppressed.
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  sequencer can accept a command.
- `cmd_load`  in  1  1 = load `cmd_data` into Rd; 0 = execute `cmd_instr`.
- `cmd_instr`  in  32  R-format instruction: opcode[31:21], Rm[20:16], shamt[15:10] (ignored), Rn[9:5], Rd[4:0].
- `cmd_data`  in  64  load value; used only when `cmd_load`=1.
- `Read1`  out  5  RF read address A = Rn.
- `Read2`  out  5  RF read address B = Rm.
- `WriteReg`  out  5  RF write address = Rd.
- `WriteData`  out  64  RF write data.
- `RegWrite`  out  1  RF write enable; the RF writes on the rising edge while this is high.
- `ALUOp`  out  2  ALU control class; 2 = R-type, 0 = idle/add.
- `Opcode`  out  11  opcode forwarded to ALU control.
- `ALU_Result`  in  64  combinational ALU output.
- `Zero`  in  1  ALU zero flag.
- `resp_valid`  out  1  response present.
- `resp_ready`  in  1  consumer accepts response.
- `resp_result`  out  64  captured ALU result, or the load value.
- `resp_zero`  out  1  captured Zero flag; for loads, 1 iff `cmd_data`==0.
- `resp_err`  out  1  opcode was not in the supported set.

## Operation
- FSM states are IDLE, EXEC, WB and RESP.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid`, latch instr, load, data.
  - If load: go to WB. Otherwise: go to EXEC.
- EXEC:
  - Drive `Read1`=Rn, `Read2`=Rm.
  - If the opcode is supported, drive `ALUOp`=2 and `Opcode`=opcode. If not, drive `ALUOp`=0 and `Opcode`=0.
  - At the end of the cycle, capture `ALU_Result`, `Zero` and the err flag.
  - Go to WB.
- Supported opcodes:
  - AND 10001010000
  - ORR 10101010000
  - ADD 10001011000
  - SUB 11001011000
  - PASSB 11111000010
  - NOR 11101010000
- WB:
  - `WriteReg`=Rd, `WriteData`=captured value.
  - `RegWrite`=1 unless err=1 or Rd==`XZR_IDX`.
  - Always one cycle; go to RESP.
- RESP:
  - `resp_valid`=1 with the captured fields.
  - Leave when `resp_valid`&&`resp_ready`, then go to IDLE.
  - Outputs are held stable while stalled.
- Outside EXEC, `Read1`/`Read2` hold their last values. `ALUOp`/`Opcode` are 0 outside EXEC.
- Rn or Rm equal to `XZR_IDX` is passed through unchanged; the RF returns its own contents, and the sequencer does not special-case reads.
- No arithmetic is performed in the block; all widths are 64-bit pass-through.

## Timing
- Reset values:
  - state=IDLE, `cmd_ready`=1 after reset deasserts.
  - `RegWrite`=0, `resp_valid`=0, `resp_err`=0, `resp_zero`=0.
  - `Read1`/`Read2`/`WriteReg`=0, `WriteData`=0, `resp_result`=0, `ALUOp`=0, `Opcode`=0.
- During reset, `cmd_ready`=0 and no command is accepted.
- Execute latency, counted from the accepting edge:
  - EXEC in cycle 1.
  - `RegWrite` high in cycle 2.
  - `resp_valid` first high in cycle 3.
- Load latency: `RegWrite` high in cycle 1; `resp_valid` in cycle 2.
- Throughput:
  - With `resp_ready` held 1: one execute every 4 cycles, one load every 3 cycles.
  - `cmd_ready` is high only in IDLE, so there is no overlap.
- Reset mid-operation:
  - Abandon the command; no write-back and no response.
  - A reset asserted during WB forces `RegWrite`=0 in the following cycle. The WB-cycle write itself completes at that edge.
- Simultaneous `cmd_valid` and reset: reset wins; the command is dropped.

## Structure
- Package `rf_alu_pkg` holds:
  - the six opcode constants;
  - the ALUOp encodings (0 = add/idle, 2 = R-type);
  - the FSM state enum;
  - the R-format field-slice helper.
- One sub-module, `rf_alu_opdecode`: combinational `opcode` → {supported, `ALUOp`, `Opcode`}. It is reused by later ALU-control work.

## Test plan
- Load: load R5=0x5555555555555555, then load R10=0xAAAAAAAAAAAAAAAA. Required: `RegWrite` pulses one cycle each with WriteReg 5 then 10; `resp_result` echoes each value.
- Execute: Rn=5, Rm=10, Rd=1, each of the six opcodes, with the ALU model attached. Required results:
  - AND → 0, `resp_zero`=1.
  - ORR → 0xFFFFFFFFFFFFFFFF.
  - ADD → 0xFFFFFFFFFFFFFFFF.
  - SUB → 0xAAAAAAAAAAAAAAAB.
  - PASSB → 0xAAAAAAAAAAAAAAAA.
  - NOR → 0.
  - Every result is written to R1.
- Unknown opcode 0: `resp_err`=1, `ALUOp`=0 in EXEC, `RegWrite` never asserts.
- Rd=31 with ADD: the response carries the result and `RegWrite` stays 0.
- Backpressure: hold `resp_ready`=0 for 5 cycles in RESP. Required: `resp_*` stable, `cmd_ready`=0, a new `cmd_valid` is not accepted until the cycle after the handshake.
- Reset asserted in EXEC: no `RegWrite` and no `resp_valid`; all outputs return to their reset values next cycle; the next command completes normally.
